// File: rtl/machine_timer_pkg.sv
// machine_timer_pkg
//   Shared address map for the machine-mode timer and the CSR bits it feeds.
//   Holds the timer window layout (register byte offsets, window size, default
//   base address), the machine CSR addresses the interrupt path touches, a
//   register-select enum and the byte-lane merge helper used on writes.
package machine_timer_pkg;

  // Machine-mode CSR addresses touched by the timer interrupt path.
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam int unsigned MIP_MTIP_BIT = 7;

  // Timer register window: four 32-bit words starting at the base address.
  localparam logic [31:0] TIMER_BASE_DEFAULT = 32'h0200_0000;
  localparam int unsigned TIMER_WINDOW_BYTES = 16;

  // Byte offsets of the timer registers within the window.
  localparam logic [3:0] MTIME_LO    = 4'h0;
  localparam logic [3:0] MTIME_HI    = 4'h4;
  localparam logic [3:0] MTIMECMP_LO = 4'h8;
  localparam logic [3:0] MTIMECMP_HI = 4'hC;

  // Word select, encoded as offset[3:2].
  typedef enum logic [1:0] {
    REG_MTIME_LO    = 2'd0,
    REG_MTIME_HI    = 2'd1,
    REG_MTIMECMP_LO = 2'd2,
    REG_MTIMECMP_HI = 2'd3
  } timer_reg_e;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/machine_timer_prescaler.sv
// timer_prescaler
//   Free-running wrap counter that divides i_clk down to the mtime increment
//   rate. Counts 0..PRESCALE-1 and raises o_tick for the one cycle in which
//   the count sits at its last value, so mtime steps once per PRESCALE cycles.
//   With PRESCALE = 1 the counter never leaves 0 and o_tick is constantly 1.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset (count back to 0)
//   o_tick  one-cycle increment strobe
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1   // 1..65535
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt;

  assign o_tick = (cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst)       cnt <= '0;
    else if (o_tick) cnt <= '0;
    else             cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/machine_timer.sv
// machine_timer
//   Memory-mapped RISC-V machine timer (single hart, RV32). Holds the 64-bit
//   mtime and mtimecmp registers as pairs of 32-bit words and drives the
//   machine timer interrupt pending level into the CSR unit.
//   Bus protocol: a request is accepted when i_req = 1 and no ack is pending;
//   o_ack pulses for exactly one cycle after the accept edge, so a request
//   held high through its ack is not taken twice.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req, i_we           request valid, 1 = write / 0 = read
//   i_addr, i_wdata, i_be byte address, write data, write byte enables
//   o_ack                 one-cycle response strobe
//   o_rdata               read data, zero whenever o_ack = 0
//   o_err                 misaligned or out-of-window access, with o_ack
//   o_Int_tip             timer interrupt pending (mtime >= mtimecmp)
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE_DEFAULT,  // 16-byte aligned
  parameter int unsigned PRESCALE  = 1,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_Int_tip
);

  logic [63:0] mtime, mtime_n;
  logic [63:0] mtimecmp, mtimecmp_n;
  logic        tick;

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  // ---------------------------------------------------------------------------
  // Address decode. Offsetting by the base first makes addresses below the
  // window wrap to huge values, so one unsigned compare covers both sides.
  // With a word-aligned base, rel[1:0] equals i_addr[1:0].
  // ---------------------------------------------------------------------------
  logic [31:0] rel;
  logic        in_win, aligned, addr_ok;
  timer_reg_e  sel;

  assign rel     = i_addr - BASE_ADDR;
  assign in_win  = (rel < 32'(TIMER_WINDOW_BYTES));
  assign aligned = (rel[1:0] == 2'b00);
  assign addr_ok = in_win && aligned;
  assign sel     = timer_reg_e'(rel[3:2]);

  // ---------------------------------------------------------------------------
  // Handshake and write strobes. An all-zero byte enable is a legal no-op.
  // ---------------------------------------------------------------------------
  logic accept, wr_en, rd_en;
  logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;

  assign accept      = i_req && !o_ack;
  assign wr_en       = accept && i_we && addr_ok && (i_be != 4'h0);
  assign rd_en       = accept && !i_we && addr_ok;
  assign wr_mtime_lo = wr_en && (sel == REG_MTIME_LO);
  assign wr_mtime_hi = wr_en && (sel == REG_MTIME_HI);
  assign wr_cmp_lo   = wr_en && (sel == REG_MTIMECMP_LO);
  assign wr_cmp_hi   = wr_en && (sel == REG_MTIMECMP_HI);

  // ---------------------------------------------------------------------------
  // Next-state values. A software write to either mtime word wins over a
  // same-cycle tick: the written word takes the new value and the other word
  // holds, so neither the increment nor a lo->hi carry lands in that cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mtime_n = mtime;
    if (wr_mtime_lo)      mtime_n[31:0]  = apply_be(mtime[31:0],  i_wdata, i_be);
    else if (wr_mtime_hi) mtime_n[63:32] = apply_be(mtime[63:32], i_wdata, i_be);
    else if (tick)        mtime_n        = mtime + 64'd1;
  end

  always_comb begin
    mtimecmp_n = mtimecmp;
    if (wr_cmp_lo) mtimecmp_n[31:0]  = apply_be(mtimecmp[31:0],  i_wdata, i_be);
    if (wr_cmp_hi) mtimecmp_n[63:32] = apply_be(mtimecmp[63:32], i_wdata, i_be);
  end

  // Read mux: register contents as they stand at the accept edge.
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (sel)
      REG_MTIME_LO:    rd_val = mtime[31:0];
      REG_MTIME_HI:    rd_val = mtime[63:32];
      REG_MTIMECMP_LO: rd_val = mtimecmp[31:0];
      REG_MTIMECMP_HI: rd_val = mtimecmp[63:32];
      default:         rd_val = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State. The interrupt compares next-state values so it moves on the same
  // edge as the tick or write that changes the relationship.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime     <= '0;
      mtimecmp  <= CMP_RESET;
      o_ack     <= 1'b0;
      o_rdata   <= '0;
      o_err     <= 1'b0;
      o_Int_tip <= 1'b0;
    end else begin
      mtime     <= mtime_n;
      mtimecmp  <= mtimecmp_n;
      o_Int_tip <= (mtime_n >= mtimecmp_n);
      o_ack     <= accept;
      o_err     <= accept && !addr_ok;
      o_rdata   <= rd_en ? rd_val : '0;
    end
  end

endmodule
